// File: rtl/prime_pkg.sv
// Shared types and constants for the prime candidate sieve.
package prime_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSieve,
    StDecide
  } sieve_state_e;

  localparam int unsigned RemW           = 4;
  localparam int unsigned NumPrimes      = 5;
  localparam int unsigned DefaultNumBits = 128;

  // Index 0 holds 3, index 4 holds 13.
  localparam logic [NumPrimes-1:0][RemW-1:0] SievePrimes = {4'd13, 4'd11, 4'd7, 4'd5, 4'd3};

  // One MSB-first trial-division step: (2*rem + bit_in) mod div.
  // Since rem < div, the sum is below 2*div and one conditional subtract suffices.
  function automatic logic [RemW-1:0] rem_step(input logic [RemW-1:0] rem,
                                               input logic            bit_in,
                                               input logic [RemW-1:0] div);
    logic [RemW:0] t;
    t = {rem, bit_in};
    if (t >= {1'b0, div}) begin
      t = t - {1'b0, div};
    end
    return t[RemW-1:0];
  endfunction

endpackage

// File: rtl/cand_fifo_fwft.sv
// First-word-fall-through candidate FIFO with registered head and flags.
module cand_fifo_fwft #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             push_ready_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d, remain;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             empty_q, empty_d, full_q, full_d;
  logic             push, pop;

  assign pop          = pop_i & ~empty_q;
  assign push_ready_o = ~full_q | pop;
  assign push         = push_i & push_ready_o;

  // Pointer, count, flag and head-register next state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Entries left after this cycle's pop, not counting this cycle's push.
    remain = count_q - {{PtrW{1'b0}}, pop};
    if (remain != '0) begin
      dout_d = mem_q[rptr_d];
    end else if (push) begin
      dout_d = wdata_i;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == DepthCnt);
  end

  // Control state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Storage; contents are only meaningful behind the pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = dout_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/prime_candidate_sieve.sv
// Conditions random words into odd full-width candidates, trial-divides them by
// small primes bit-serially and queues survivors for the primality controller.
module prime_candidate_sieve
  import prime_pkg::*;
#(
  parameter int unsigned NUM_BITS   = DefaultNumBits,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          SIEVE_EN   = 1'b1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                rnd_valid,
  input  logic [NUM_BITS-1:0] rnd_data,
  output logic                rnd_ready,
  input  logic                pq_fifo_rd_en,
  output logic [NUM_BITS-1:0] pq_fifo_dout,
  output logic                pq_fifo_empty,
  output logic                pq_fifo_full,
  output logic [31:0]         reject_count
);

  localparam int unsigned CntW = $clog2(NUM_BITS);
  localparam logic [NUM_BITS-1:0] CondMask = {1'b1, {(NUM_BITS - 2){1'b0}}, 1'b1};

  sieve_state_e                   state_q, state_d;
  logic [NUM_BITS-1:0]            cand_q, cand_d, shift_q, shift_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic [NumPrimes-1:0][RemW-1:0] rem_q, rem_d;
  logic [31:0]                    rej_q, rej_d;
  logic                           rdy_q, rdy_d;
  logic                           fifo_push, fifo_ready, divisible;

  // FSM next state, bit-serial remainder update and reject counting.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    rej_d     = rej_q;
    fifo_push = 1'b0;
    divisible = 1'b0;
    for (int i = 0; i < NumPrimes; i++) begin
      if (rem_q[i] == '0) divisible = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (rnd_valid && rdy_q) begin
          cand_d  = rnd_data | CondMask;
          shift_d = rnd_data | CondMask;
          rem_d   = '0;
          cnt_d   = CntW'(NUM_BITS - 1);
          state_d = StSieve;
        end
      end
      StSieve: begin
        for (int i = 0; i < NumPrimes; i++) begin
          rem_d[i] = rem_step(rem_q[i], shift_q[NUM_BITS-1], SievePrimes[i]);
        end
        shift_d = shift_q << 1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = StDecide;
      end
      StDecide: begin
        if (SIEVE_EN && divisible) begin
          if (rej_q != '1) rej_d = rej_q + 1'b1;
          state_d = StIdle;
        end else begin
          // Held high while stalled; the FIFO takes it once a slot frees up.
          fifo_push = 1'b1;
          if (fifo_ready) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered so ready stays low throughout reset and rises one cycle after.
    rdy_d = (state_d == StIdle);
  end

  // State registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      cand_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      rej_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      rej_q   <= rej_d;
      rdy_q   <= rdy_d;
    end
  end

  cand_fifo_fwft #(
    .WIDTH (NUM_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (aclk),
    .rst_ni       (aresetn),
    .push_i       (fifo_push),
    .wdata_i      (cand_q),
    .push_ready_o (fifo_ready),
    .pop_i        (pq_fifo_rd_en),
    .rdata_o      (pq_fifo_dout),
    .empty_o      (pq_fifo_empty),
    .full_o       (pq_fifo_full)
  );

  assign rnd_ready    = rdy_q;
  assign reject_count = rej_q;

endmodule
